conv_frame_sequencer: RTL and testbench

Frame-level controller for the 3x3 convolution path. On a start request it drives the 0..68 cycle counter that the conv datapath and the conv result storage registers decode. It flags the 36 cycles in which a valid 6x6 output pixel is present and supplies that pixel's row, column and linear buffer address. It reports busy/done to the layer scheduler and supports a pipeline stall that freezes the frame.

---
 rtl/conv_frame_sequencer.sv | 105 ++++++++++
 tb/tb_conv_frame_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_sequencer.sv
// Frame sequencer for the 3x3 convolution path: drives the frame counter, flags the
// valid output-pixel windows and their coordinates. Optional macro: CONV_SEQ_AUTO_RESTART_EN.
module conv_frame_sequencer #(
  parameter int CNT_MAX    = 68,
  parameter int FIRST_CAP  = 20,
  parameter int ROW_PERIOD = 8,
  parameter int ROW_LEN    = 6,
  parameter int N_ROWS     = 6,
  localparam int CW        = $clog2(CNT_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  output logic [CW-1:0] cnt,
  output logic          cap_en,
  output logic [2:0]    out_row,
  output logic [2:0]    out_col,
  output logic [5:0]    out_addr,
  output logic          busy,
  output logic          done,
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_MAX_C    = CW'(CNT_MAX);
  localparam logic [CW-1:0] FIRST_CAP_C  = CW'(FIRST_CAP);
  localparam logic [CW-1:0] ROW_PERIOD_C = CW'(ROW_PERIOD);
  localparam logic [CW-1:0] ROW_LEN_C    = CW'(ROW_LEN);
  localparam logic [CW-1:0] N_ROWS_C     = CW'(N_ROWS);

  state_t        state_q;
  logic          past_first;
  logic [CW-1:0] d;
  logic [CW-1:0] row_full;
  logic [CW-1:0] col_full;
  logic          in_window;

  // d is forced to zero before the first capture so the subtraction never wraps.
  always_comb begin
    past_first = (cnt >= FIRST_CAP_C);
    d          = past_first ? (cnt - FIRST_CAP_C) : '0;
    row_full   = d / ROW_PERIOD_C;
    col_full   = d % ROW_PERIOD_C;
    in_window  = past_first && (col_full < ROW_LEN_C) && (row_full < N_ROWS_C);
    cap_en     = (state_q == RUN) && !stall && in_window;
    out_row    = cap_en ? row_full[2:0] : 3'd0;
    out_col    = cap_en ? col_full[2:0] : 3'd0;
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE) && !stall;
  assign fsm_state = state_q;

  // A stalled cycle freezes every register, so a pending transition simply waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt      <= '0;
      out_addr <= '0;
    end else if (!stall) begin
      case (state_q)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            state_q  <= RUN;
            out_addr <= '0;
          end
        end
        RUN: begin
          if (cnt == CNT_MAX_C) begin
            state_q <= DONE;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
          if (cap_en) out_addr <= out_addr + 6'd1;
        end
        DONE: begin
`ifdef CONV_SEQ_AUTO_RESTART_EN
          if (start) begin
            state_q  <= RUN;
            cnt      <= '0;
            out_addr <= '0;
          end else begin
            state_q <= IDLE;
          end
`else
          state_q <= IDLE;
`endif
        end
        default: begin
          state_q <= IDLE;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer: full frames, stall, start pokes,
// mid-frame reset and held start, with hand-derived capture windows.
module tb_conv_frame_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stall;
  logic [6:0] cnt;
  logic       cap_en;
  logic [2:0] out_row;
  logic [2:0] out_col;
  logic [5:0] out_addr;
  logic       busy;
  logic       done;
  logic [1:0] fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  conv_frame_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stall     (stall),
    .cnt       (cnt),
    .cap_en    (cap_en),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_addr  (out_addr),
    .busy      (busy),
    .done      (done),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cnt"},      32'(cnt),      0);
    chk({tag, "_cap_en"},   32'(cap_en),   0);
    chk({tag, "_out_row"},  32'(out_row),  0);
    chk({tag, "_out_col"},  32'(out_col),  0);
    chk({tag, "_out_addr"}, 32'(out_addr), 0);
    chk({tag, "_busy"},     32'(busy),     0);
    chk({tag, "_done"},     32'(done),     0);
    chk({tag, "_state"},    32'(fsm_state), 0);
  endtask

  // Entered on the first RUN cycle (cnt=0). Ends on the DONE cycle.
  task automatic run_frame(input int stall_at, input int stall_len, input int poke_at,
                           input bit hold);
    int addr_exp = 0;
    int caps     = 0;
    int edges    = 0;
    int dones    = 0;
    bit exp_cap;
    int er, ec;
    for (int k = 0; k <= 68; k++) begin
      if (k == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          stall = 1'b1;
          #1;
          chk("stall_cnt",    32'(cnt),      32'(k));
          chk("stall_cap_en", 32'(cap_en),   0);
          chk("stall_addr",   32'(out_addr), 32'(addr_exp));
          chk("stall_busy",   32'(busy),     1);
          tick();
          edges++;
        end
        stall = 1'b0;
      end
      start = hold || (k == poke_at);
      #1;
      // Windows start at 20,28,...,60 and are 6 counts long.
      exp_cap = 1'b0;
      er = 0;
      ec = 0;
      for (int w = 0; w < 6; w++) begin
        if (k >= 20 + 8 * w && k < 26 + 8 * w) begin
          exp_cap = 1'b1;
          er = w;
          ec = k - (20 + 8 * w);
        end
      end
      if (k == 0 || k == 20 || k == 25 || k == 26 || k == 65 || k == 66 || k == 68) begin
        chk("run_cnt", 32'(cnt), 32'(k));
        chk("run_busy", 32'(busy), 1);
      end else if (cnt !== 7'(k) || busy !== 1'b1) begin
        chk("run_cnt_seq", 32'(cnt), 32'(k));
      end
      if (done === 1'b1) dones++;
      if (cap_en !== exp_cap) chk($sformatf("cap_en_at_%0d", k), 32'(cap_en), 32'(exp_cap));
      if (exp_cap) begin
        if (out_row !== 3'(er) || out_col !== 3'(ec) || out_addr !== 6'(addr_exp)) begin
          chk($sformatf("pix_row_%0d", k),  32'(out_row),  32'(er));
          chk($sformatf("pix_col_%0d", k),  32'(out_col),  32'(ec));
          chk($sformatf("pix_addr_%0d", k), 32'(out_addr), 32'(addr_exp));
        end
        addr_exp++;
      end else if (out_row !== 3'd0 || out_col !== 3'd0) begin
        chk($sformatf("idle_rowcol_%0d", k), 32'({out_row, out_col}), 0);
      end
      if (cap_en === 1'b1) caps++;
      tick();
      edges++;
    end
    chk("done_pulse",    32'(done),     1);
    chk("done_busy",     32'(busy),     1);
    chk("done_cnt",      32'(cnt),      0);
    chk("done_addr",     32'(out_addr), 36);
    chk("done_latency",  32'(edges),    32'(69 + stall_len));
    chk("cap_count",     32'(caps),     36);
    chk("no_early_done", 32'(dones),    0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    tick();
    tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 0);

    // Plain frame
    start = 1'b1;
    tick();
    chk("start_busy", 32'(busy), 1);
    chk("start_cnt",  32'(cnt),  0);
    run_frame(-1, 0, -1, 1'b0);
    tick();
    chk("after_done_busy", 32'(busy),     0);
    chk("after_done_done", 32'(done),     0);
    chk("after_done_addr", 32'(out_addr), 36);

    // Start poked mid-frame is ignored
    start = 1'b1;
    tick();
    chk("restart_addr_clear", 32'(out_addr), 0);
    run_frame(-1, 0, 10, 1'b0);
    tick();
    chk("poke_idle_busy", 32'(busy), 0);

    // Three-cycle stall at cnt=22
    start = 1'b1;
    tick();
    run_frame(22, 3, -1, 1'b0);
    tick();
    chk("stall_idle_busy", 32'(busy), 0);

    // Reset at cnt=40
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("pre_rst_cnt", 32'(cnt), 40);
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 75; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) chk("post_rst_quiet", 32'({busy, done}), 0);
    end
    chk("post_rst_idle", 32'(busy), 0);

    // Start held through a frame
    start = 1'b1;
    tick();
    run_frame(-1, 0, -1, 1'b1);
    tick();
`ifdef CONV_SEQ_AUTO_RESTART_EN
    chk("auto_busy", 32'(busy),     1);
    chk("auto_cnt",  32'(cnt),      0);
    chk("auto_addr", 32'(out_addr), 0);
`else
    chk("gap_busy",  32'(busy),      0);
    chk("gap_state", 32'(fsm_state), 0);
    tick();
    chk("gap_restart_busy", 32'(busy), 1);
    chk("gap_restart_cnt",  32'(cnt),  0);
`endif
    run_frame(-1, 0, -1, 1'b0);
    tick();
    chk("final_idle_busy", 32'(busy), 0);
    chk("final_idle_done", 32'(done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
